survivor_mem_writer: RTL and testbench
======================================

// Module: survivor_mem_writer
// PURPOSE
//  Circular survivor-path memory between the ACS array and the traceback unit. Each accepted
//  ACS column (one survivor bit per state) is written at the next column slot. The block
//  publishes the newest-column index and answers the traceback bit-read port. It also
//  generates the traceback start pulse, which drives the traceback force_state0 input.
// PARAMETERS
//  M            6    state bits; NS = 2**M survivor bits per column
//  D            40   columns in memory (traceback depth); AW = $clog2(D)
//  TB_INTERVAL  8    accepted columns between successive tb_start requests once memory is full
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, synchronous, active-high
//  surv_valid   in   1     surv_col valid this cycle; accepted unconditionally (no backpressure)
//  surv_col     in   NS    survivor bits, bit s = survivor for state s
//  flush        in   1     synchronous restart of pointers/counters; RAM contents kept
//  wr_ptr       out  AW    index of most recently written column (traceback start time)
//  tb_time      in   AW    traceback read column
//  tb_state     in   M     traceback read state
//  tb_surv_bit  out  1     surv[tb_time][tb_state]
//  tb_busy      in   1     traceback engine busy (not IDLE)
//  tb_start     out  1     one-cycle request to begin traceback from wr_ptr
//  full         out  1     D columns written since reset/flush
//  overrun      out  1     sticky: a start request came due while one was already pending
// BEHAVIOUR
//  - Reset/flush: nxt_ptr=0, wr_ptr=D-1, fill_cnt=0, int_cnt=0, pending=0, tb_start=0,
//    full=0, overrun=0. tb_surv_bit resets to 0 only under SURV_RD_REG_EN.
//  - rst has priority over flush; flush has priority over surv_valid in the same cycle.
//  - Write on surv_valid: ram[nxt_ptr] <= surv_col; wr_ptr <= nxt_ptr;
//    nxt_ptr <= (nxt_ptr==D-1) ? 0 : nxt_ptr+1. wr_ptr updates in the same edge as the write.
//  - fill_cnt saturates at D. full=1 from the edge at which fill_cnt reaches D.
//  - Start request "due":
//    - on the write that makes fill_cnt reach D;
//    - thereafter when int_cnt reaches TB_INTERVAL. int_cnt counts accepted writes while full,
//      clears on each due event.
//  - Start arbitration (registered):
//    - due and !tb_busy and !pending: tb_start=1 next cycle.
//    - due while tb_busy: pending<=1.
//    - pending and !tb_busy: tb_start=1, pending<=0.
//    - due while pending: overrun<=1 (sticky until rst/flush); pending stays 1.
//  - tb_start is never high on two consecutive cycles. It is never asserted while tb_busy was
//    high in the cycle it was decided.
//  - Read path (default): tb_surv_bit = ram[tb_time][tb_state], combinational, 0-cycle latency.
//    This matches the traceback's use of the bit in the cycle after it registers
//    tb_time/tb_state.
//  - Read/write same column, same cycle: the read returns the old (pre-write) contents.
//  - tb_time >= D: tb_surv_bit = 0. The write side is unaffected.
//  - Writes continue during traceback. Keeping TB_INTERVAL*columns-per-traceback below D is a
//    system property, not checked here.
// CONFIGURATION
//  SURV_RD_REG_EN defined:
//    - tb_surv_bit registered: value = ram[tb_time][tb_state] sampled at the previous edge
//      (1-cycle latency), reset 0.
//    - The collision rule applies at the sampling edge.
//    - The traceback must then discard one extra step.
//  Undefined: combinational read as above.
// STRUCTURE
//  - viterbi_pkg:
//    - localparams NS(M) and AW(D);
//    - typedef surv_col_t [NS-1:0] and col_idx_t [AW-1:0];
//    - function wrap_inc(idx, D).
//  - Sub-module surv_ram: D x NS bit array, one write port, one bit-select read port;
//    holds the SURV_RD_REG_EN register.
//  - Pointer/fill/interval counters and the start arbiter stay in the top module.
// TESTING
//  1 Reset: hold rst 2 cycles -> wr_ptr=39, full=0, tb_start=0, overrun=0.
//  2 Fill: 40 writes, surv_col=col_index pattern, tb_busy=0 -> full and tb_start rise one
//    cycle after the 40th write; wr_ptr=39.
//  3 Readback: after fill, sweep tb_time 0..39 x tb_state 0..63 -> bit equals written pattern
//    (check also with SURV_RD_REG_EN, 1-cycle lag).
//  4 Wrap/interval: 8 more writes -> wr_ptr=7, second tb_start after 8th; column 0 now new data.
//  5 Busy defer: tb_busy=1 across a due event -> no tb_start; drop tb_busy -> tb_start next
//    cycle; a second due while pending -> overrun=1.
//  6 Collision/flush: write col 5 while tb_time=5 -> old bit returned; flush -> wr_ptr=39,
//    full=0, RAM data unchanged.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared survivor-memory sizes, types and index helper
package viterbi_pkg;
  localparam int SURV_M           = 6;
  localparam int SURV_D           = 40;
  localparam int SURV_TB_INTERVAL = 8;
  localparam int NS               = 2 ** SURV_M;
  localparam int AW               = $clog2(SURV_D);

  typedef logic [NS-1:0] surv_col_t;
  typedef logic [AW-1:0] col_idx_t;

  function automatic int wrap_inc(input int idx, input int d);
    return (idx == d - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/surv_ram.sv
// rtl/surv_ram.sv - D x NS survivor bit array, one column write port, one bit read port
// SURV_RD_REG_EN: register the read bit (1-cycle latency) instead of a combinational read.
module surv_ram #(
  parameter int M = 6,
  parameter int D = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [$clog2(D)-1:0] i_waddr,
  input  logic [2**M-1:0]      i_wdata,
  input  logic [$clog2(D)-1:0] i_raddr,
  input  logic [M-1:0]         i_rsel,
  output logic                 o_rbit
);
  logic [2**M-1:0] r_mem [D];
  logic            w_rd_bit;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Columns past D-1 do not exist; they read as zero.
  assign w_rd_bit = (int'(i_raddr) < D) ? r_mem[i_raddr][i_rsel] : 1'b0;

`ifdef SURV_RD_REG_EN
  logic r_rbit;

  always_ff @(posedge clk) begin
    if (rst) r_rbit <= 1'b0;
    else     r_rbit <= w_rd_bit;
  end

  assign o_rbit = r_rbit;
`else
  logic w_unused;

  assign w_unused = rst;
  assign o_rbit   = w_rd_bit;
`endif
endmodule

// File: rtl/survivor_mem_writer.sv
// rtl/survivor_mem_writer.sv - circular survivor memory writer with traceback start arbiter
// SURV_RD_REG_EN: selects the registered traceback read path inside surv_ram.
module survivor_mem_writer
  import viterbi_pkg::*;
#(
  parameter int M           = SURV_M,
  parameter int D           = SURV_D,
  parameter int TB_INTERVAL = SURV_TB_INTERVAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 surv_valid,
  input  logic [2**M-1:0]      surv_col,
  input  logic                 flush,
  output logic [$clog2(D)-1:0] wr_ptr,
  input  logic [$clog2(D)-1:0] tb_time,
  input  logic [M-1:0]         tb_state,
  output logic                 tb_surv_bit,
  input  logic                 tb_busy,
  output logic                 tb_start,
  output logic                 full,
  output logic                 overrun
);
  localparam int IDX_W  = $clog2(D);
  localparam int FILL_W = $clog2(D + 1);
  localparam int INT_W  = $clog2(TB_INTERVAL + 1);

  logic [IDX_W-1:0]  r_nxt_ptr;
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [INT_W-1:0]  r_int_cnt;
  logic              r_pending;
  logic              r_tb_start;
  logic              r_full;
  logic              r_overrun;

  logic w_we;
  logic w_fill_hit;
  logic w_int_hit;
  logic w_due;
  logic w_req;
  logic w_fire;

  assign w_we       = surv_valid && !flush;
  assign w_fill_hit = w_we && (r_fill_cnt == FILL_W'(D - 1));
  assign w_int_hit  = w_we && r_full && (r_int_cnt == INT_W'(TB_INTERVAL - 1));
  assign w_due      = w_fill_hit || w_int_hit;
  assign w_req      = w_due || r_pending;
  // Blocking on r_tb_start keeps pulses at least one idle cycle apart.
  assign w_fire     = w_req && !tb_busy && !r_tb_start;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_nxt_ptr  <= '0;
      r_wr_ptr   <= IDX_W'(D - 1);
      r_fill_cnt <= '0;
      r_int_cnt  <= '0;
      r_pending  <= 1'b0;
      r_tb_start <= 1'b0;
      r_full     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_we) begin
        r_wr_ptr  <= r_nxt_ptr;
        r_nxt_ptr <= IDX_W'(wrap_inc(int'(r_nxt_ptr), D));
        if (r_fill_cnt != FILL_W'(D)) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_fill_hit) r_full <= 1'b1;
      if (w_due)                r_int_cnt <= '0;
      else if (w_we && r_full)  r_int_cnt <= r_int_cnt + 1'b1;
      r_tb_start <= w_fire;
      // A due arriving on top of a pending request leaves one request outstanding.
      r_pending  <= (w_due && r_pending) || (w_req && !w_fire);
      if (w_due && r_pending) r_overrun <= 1'b1;
    end
  end

  assign wr_ptr   = r_wr_ptr;
  assign tb_start = r_tb_start;
  assign full     = r_full;
  assign overrun  = r_overrun;

  surv_ram #(
    .M(M),
    .D(D)
  ) u_surv_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_nxt_ptr),
    .i_wdata (surv_col),
    .i_raddr (tb_time),
    .i_rsel  (tb_state),
    .o_rbit  (tb_surv_bit)
  );
endmodule

// File: tb/tb_survivor_mem_writer.sv
// tb/tb_survivor_mem_writer.sv - self-checking bench for survivor_mem_writer
module tb_survivor_mem_writer;
  import viterbi_pkg::*;

  localparam int D = SURV_D;

  logic        clk = 1'b0;
  logic        rst;
  logic        surv_valid;
  surv_col_t   surv_col;
  logic        flush;
  col_idx_t    wr_ptr;
  col_idx_t    tb_time;
  logic [SURV_M-1:0] tb_state;
  logic        tb_surv_bit;
  logic        tb_busy;
  logic        tb_start;
  logic        full;
  logic        overrun;

  surv_col_t model_mem [D];
  int        model_nxt;
  bit        exp_q [$];
  int        checks;
  int        failures;

  always #5 clk = ~clk;

  survivor_mem_writer dut (
    .clk         (clk),
    .rst         (rst),
    .surv_valid  (surv_valid),
    .surv_col    (surv_col),
    .flush       (flush),
    .wr_ptr      (wr_ptr),
    .tb_time     (tb_time),
    .tb_state    (tb_state),
    .tb_surv_bit (tb_surv_bit),
    .tb_busy     (tb_busy),
    .tb_start    (tb_start),
    .full        (full),
    .overrun     (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_col(input surv_col_t d);
    surv_valid = 1'b1;
    surv_col   = d;
    model_mem[model_nxt] = d;
    model_nxt  = (model_nxt + 1) % D;
    step();
    surv_valid = 1'b0;
  endtask

  // Drives a read address, queues the expected bit and waits out the read latency.
  task automatic rd_issue(input int t, input int s);
    tb_time  = col_idx_t'(t);
    tb_state = s[SURV_M-1:0];
    exp_q.push_back((t < D) ? model_mem[t][s] : 1'b0);
`ifdef SURV_RD_REG_EN
    step();
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; surv_valid = 1'b0; surv_col = '0;
    tb_time = '0; tb_state = '0; tb_busy = 1'b0;
    model_nxt = 0;
    step(); step();
    rst = 1'b0;
    checks += 4;
    if (wr_ptr !== col_idx_t'(D - 1)) begin failures++; $display("FAIL reset_wr_ptr got=%0d exp=%0d", wr_ptr, D - 1); end
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    if (tb_start !== 1'b0) begin failures++; $display("FAIL reset_tb_start got=%b exp=0", tb_start); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`ifdef SURV_RD_REG_EN
    checks++;
    if (tb_surv_bit !== 1'b0) begin failures++; $display("FAIL reset_rd_bit got=%b exp=0", tb_surv_bit); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      write_col({$urandom, $urandom});
      checks += 3;
      if (wr_ptr !== col_idx_t'(i)) begin failures++; $display("FAIL fill_wr_ptr i=%0d got=%0d exp=%0d", i, wr_ptr, i); end
      if (full !== (i == D - 1)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i == D - 1); end
      if (tb_start !== (i == D - 1)) begin failures++; $display("FAIL fill_tb_start i=%0d got=%b exp=%b", i, tb_start, i == D - 1); end
    end
    step();
    checks++;
    if (tb_start !== 1'b0) begin failures++; $display("FAIL fill_start_pulse got=%b exp=0", tb_start); end
  endtask

  task automatic test_readback();
    bit e;
    for (int t = 0; t < D; t++) begin
      for (int s = 0; s < NS; s++) begin
        rd_issue(t, s);
        e = exp_q.pop_front();
        checks++;
        if (tb_surv_bit !== e) begin failures++; $display("FAIL readback t=%0d s=%0d got=%b exp=%b", t, s, tb_surv_bit, e); end
      end
    end
    rd_issue(D + 5, 3);
    e = exp_q.pop_front();
    checks++;
    if (tb_surv_bit !== e) begin failures++; $display("FAIL read_oob got=%b exp=%b", tb_surv_bit, e); end
    step();
  endtask

  task automatic test_wrap();
    bit e;
    for (int i = 0; i < SURV_TB_INTERVAL; i++) begin
      write_col({$urandom, $urandom});
      checks++;
      if (tb_start !== (i == SURV_TB_INTERVAL - 1)) begin failures++; $display("FAIL wrap_tb_start i=%0d got=%b exp=%b", i, tb_start, i == SURV_TB_INTERVAL - 1); end
    end
    checks++;
    if (wr_ptr !== col_idx_t'(SURV_TB_INTERVAL - 1)) begin failures++; $display("FAIL wrap_wr_ptr got=%0d exp=%0d", wr_ptr, SURV_TB_INTERVAL - 1); end
    for (int s = 0; s < NS; s++) begin
      rd_issue(0, s);
      e = exp_q.pop_front();
      checks++;
      if (tb_surv_bit !== e) begin failures++; $display("FAIL wrap_col0 s=%0d got=%b exp=%b", s, tb_surv_bit, e); end
    end
    step();
  endtask

  task automatic test_busy_defer();
    tb_busy = 1'b1;
    for (int i = 0; i < SURV_TB_INTERVAL; i++) begin
      write_col({$urandom, $urandom});
      checks++;
      if (tb_start !== 1'b0) begin failures++; $display("FAIL busy_no_start i=%0d got=%b exp=0", i, tb_start); end
    end
    tb_busy = 1'b0;
    step();
    checks += 2;
    if (tb_start !== 1'b1) begin failures++; $display("FAIL busy_release_start got=%b exp=1", tb_start); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL busy_overrun_early got=%b exp=0", overrun); end
    step();
    checks++;
    if (tb_start !== 1'b0) begin failures++; $display("FAIL busy_start_one_cycle got=%b exp=0", tb_start); end
    tb_busy = 1'b1;
    for (int i = 0; i < 2 * SURV_TB_INTERVAL; i++) begin
      write_col({$urandom, $urandom});
      checks += 2;
      if (tb_start !== 1'b0) begin failures++; $display("FAIL ovr_no_start i=%0d got=%b exp=0", i, tb_start); end
      if (overrun !== (i == 2 * SURV_TB_INTERVAL - 1)) begin failures++; $display("FAIL ovr_flag i=%0d got=%b exp=%b", i, overrun, i == 2 * SURV_TB_INTERVAL - 1); end
    end
    tb_busy = 1'b0;
    step();
    checks += 2;
    if (tb_start !== 1'b1) begin failures++; $display("FAIL ovr_release_start got=%b exp=1", tb_start); end
    if (wr_ptr !== col_idx_t'((model_nxt + D - 1) % D)) begin failures++; $display("FAIL ovr_wr_ptr got=%0d exp=%0d", wr_ptr, (model_nxt + D - 1) % D); end
    step();
    checks += 2;
    if (tb_start !== 1'b0) begin failures++; $display("FAIL ovr_start_one_cycle got=%b exp=0", tb_start); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_collision_flush();
    surv_col_t old_d;
    surv_col_t new_d;
    bit        e;
    while (model_nxt != 5) write_col({$urandom, $urandom});
    step();
    old_d = model_mem[5];
    new_d = ~old_d;
    tb_time = col_idx_t'(5); tb_state = 6'd17;
    surv_valid = 1'b1; surv_col = new_d;
    exp_q.push_back(old_d[17]);
`ifdef SURV_RD_REG_EN
    step();
`else
    #1;
`endif
    e = exp_q.pop_front();
    checks++;
    if (tb_surv_bit !== e) begin failures++; $display("FAIL collision_old got=%b exp=%b", tb_surv_bit, e); end
`ifndef SURV_RD_REG_EN
    step();
`endif
    surv_valid = 1'b0;
    model_mem[5] = new_d;
    model_nxt = 6;
    checks++;
    if (wr_ptr !== col_idx_t'(5)) begin failures++; $display("FAIL collision_wr_ptr got=%0d exp=5", wr_ptr); end
    rd_issue(5, 17);
    e = exp_q.pop_front();
    checks++;
    if (tb_surv_bit !== e) begin failures++; $display("FAIL collision_new got=%b exp=%b", tb_surv_bit, e); end
    step();
    flush = 1'b1; surv_valid = 1'b1; surv_col = ~model_mem[6];
    step();
    flush = 1'b0; surv_valid = 1'b0;
    checks += 4;
    if (wr_ptr !== col_idx_t'(D - 1)) begin failures++; $display("FAIL flush_wr_ptr got=%0d exp=%0d", wr_ptr, D - 1); end
    if (full !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", full); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL flush_overrun got=%b exp=0", overrun); end
    if (tb_start !== 1'b0) begin failures++; $display("FAIL flush_tb_start got=%b exp=0", tb_start); end
    for (int t = 0; t < D; t++) begin
      for (int s = 0; s < NS; s += 7) begin
        rd_issue(t, s);
        e = exp_q.pop_front();
        checks++;
        if (tb_surv_bit !== e) begin failures++; $display("FAIL flush_ram t=%0d s=%0d got=%b exp=%b", t, s, tb_surv_bit, e); end
      end
    end
    step();
    model_nxt = 0;
    write_col({$urandom, $urandom});
    checks += 2;
    if (wr_ptr !== col_idx_t'(0)) begin failures++; $display("FAIL post_flush_wr_ptr got=%0d exp=0", wr_ptr); end
    if (full !== 1'b0) begin failures++; $display("FAIL post_flush_full got=%b exp=0", full); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_readback();
    test_wrap();
    test_busy_defer();
    test_collision_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
